// File: rtl/hazard_stall_controller.sv
// Pipeline hazard and memory-wait sequencer for the five-stage ARM datapath.
// Drives PC/IF-ID/ID-EX enables and keeps stall and memory-timeout bookkeeping.
//
// state | meaning
// RUN   | normal flow; hazards evaluated, stall emitted in the detecting cycle
// STALL | extra bubble cycles of a two-cycle hazard still pending (cnt left)
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ID_opcode,
  input  logic [31:0]      EX_opcode,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       srcReg1,
  input  logic [4:0]       srcReg2,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [1:0]        cnt, cnt_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              timeout_q;

  logic [4:0] rd_ex;
  logic       rd_valid;
  logic       id_is_bcond, id_is_cbz, ex_sets_flags;
  logic       haz_load_use, haz_cbz_reg, haz_cbz_load, haz_flags;
  logic       mem_wait, timeout_hit;
  logic       unused_ok;

  assign rd_ex         = EX_opcode[4:0];
  assign rd_valid      = (rd_ex != 5'd31);
  assign id_is_bcond   = (ID_opcode[31:24] == 8'b01010100);
  assign id_is_cbz     = (ID_opcode[31:24] == 8'b10110100);
  assign ex_sets_flags = (EX_opcode[31:21] == 11'b10101011000) ||
                         (EX_opcode[31:21] == 11'b11101011000);

  assign haz_load_use = EX_MemRead && rd_valid && ((rd_ex == srcReg1) || (rd_ex == srcReg2));
  assign haz_cbz_reg  = id_is_cbz && EX_RegWrite && !EX_MemRead && rd_valid &&
                        (rd_ex == ID_opcode[4:0]);
  assign haz_cbz_load = id_is_cbz && EX_MemRead && rd_valid && (rd_ex == ID_opcode[4:0]);
  assign haz_flags    = id_is_bcond && ex_sets_flags;

  assign mem_wait    = mem_req && !mem_ready;
  // The flag is visible already in the wait cycle that reaches the limit.
  assign timeout_hit = mem_wait && (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1));
  assign mem_timeout = timeout_q || timeout_hit;

  assign unused_ok = ^{ID_opcode[23:5], EX_opcode[20:5]};

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (mem_wait) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      pipe_hold   = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (haz_cbz_load || haz_load_use || haz_cbz_reg || haz_flags) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
          if (haz_cbz_load) begin
            state_next = STALL;
            cnt_next   = 2'd1;
          end
        end
        STALL: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (cnt <= 2'd1) begin
            state_next = RUN;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt - 2'd1;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    wait_cnt_next = '0;
    if (mem_wait) begin
      if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) wait_cnt_next = wait_cnt;
      else                                  wait_cnt_next = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= 2'd0;
      wait_cnt     <= '0;
      timeout_q    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_hit) timeout_q <= 1'b1;
      if (!PC_Write && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed scenarios plus random
// traffic, checked against a pending-bubble / wait-length reference model.
module tb_hazard_stall_controller;

  localparam int T_OUT  = 4;
  localparam int CW     = 6;
  localparam int SC_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   ID_opcode = '0, EX_opcode = '0;
  logic          EX_RegWrite = 1'b0, EX_MemRead = 1'b0;
  logic [4:0]    srcReg1 = '0, srcReg2 = '0;
  logic          mem_req = 1'b0, mem_ready = 1'b0;
  logic          PC_Write, IF_ID_Write, ID_EX_Bubble, pipe_hold, mem_timeout;
  logic [CW-1:0] stall_cycles;

  hazard_stall_controller #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ID_opcode(ID_opcode), .EX_opcode(EX_opcode),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .srcReg1(srcReg1),
    .srcReg2(srcReg2), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .pipe_hold(pipe_hold), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pc, ifid, bub, hold, to;
    int   sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // reference model state
  int pending = 0;
  int wait_n  = 0;
  int sc      = 0;
  bit to_flag = 0;

  localparam logic [31:0] LDUR_OP = 32'hF840_0000;
  localparam logic [31:0] SUBS_OP = 32'hEB00_0000;
  localparam logic [31:0] ADDS_OP = 32'hAB00_0000;
  localparam logic [31:0] ADD_OP  = 32'h8B00_0000;
  localparam logic [31:0] CBZ_OP  = 32'hB400_0000;
  localparam logic [31:0] BC_OP   = 32'h5400_0000;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int haz_len(input logic [31:0] id, input logic [31:0] ex,
                                 input logic rw, input logic mr,
                                 input logic [4:0] s1, input logic [4:0] s2);
    int len;
    logic [4:0] rd;
    bit ok, cbz, bc, fl;
    len = 0;
    rd  = ex[4:0];
    ok  = (rd != 5'd31);
    cbz = (id[31:24] == 8'hB4);
    bc  = (id[31:24] == 8'h54);
    fl  = (ex[31:21] == 11'b10101011000) || (ex[31:21] == 11'b11101011000);
    if (mr && ok && (rd == s1 || rd == s2)) len = 1;
    if (cbz && rw && !mr && ok && rd == id[4:0]) len = 1;
    if (bc && fl) len = 1;
    if (cbz && mr && ok && rd == id[4:0]) len = 2;
    return len;
  endfunction

  task automatic push_idle();
    exp_t e;
    e.pc = 1; e.ifid = 1; e.bub = 0; e.hold = 0; e.to = 0; e.sc = 0;
    q.push_back(e);
  endtask

  // One clock cycle of stimulus; expected outputs go to the scoreboard.
  task automatic step(input logic [31:0] id, input logic [31:0] ex,
                      input logic rw, input logic mr,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic mq, input logic my);
    exp_t e;
    int   len;
    @(posedge clk);
    #1;
    ID_opcode = id; EX_opcode = ex; EX_RegWrite = rw; EX_MemRead = mr;
    srcReg1 = s1; srcReg2 = s2; mem_req = mq; mem_ready = my;
    e.sc = sc;
    e.pc = 1; e.ifid = 1; e.bub = 0; e.hold = 0;
    if (mq && !my) begin
      e.pc = 0; e.ifid = 0; e.hold = 1;
      e.to = to_flag || (wait_n + 1 >= T_OUT);
      wait_n = (wait_n + 1 > T_OUT) ? T_OUT : wait_n + 1;
      if (wait_n >= T_OUT) to_flag = 1;
    end else begin
      wait_n = 0;
      e.to = to_flag;
      if (pending > 0) begin
        e.pc = 0; e.ifid = 0; e.bub = 1;
        pending--;
      end else begin
        len = haz_len(id, ex, rw, mr, s1, s2);
        if (len > 0) begin
          e.pc = 0; e.ifid = 0; e.bub = 1;
          pending = len - 1;
        end
      end
    end
    if (!e.pc && sc < SC_MAX) sc++;
    q.push_back(e);
  endtask

  task automatic idle();
    step('0, '0, 0, 0, 5'd0, 5'd0, 0, 0);
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    @(posedge clk);
    #1;
    ID_opcode = '0; EX_opcode = '0; EX_RegWrite = 0; EX_MemRead = 0;
    srcReg1 = '0; srcReg2 = '0; mem_req = 0; mem_ready = 0;
    #2 reset = 1'b1;
    pending = 0; wait_n = 0; sc = 0; to_flag = 0;
    push_idle();
    @(posedge clk);
    #1 push_idle();
    #5 reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC_Write", int'(PC_Write), int'(e.pc));
        chk("IF_ID_Write", int'(IF_ID_Write), int'(e.ifid));
        chk("ID_EX_Bubble", int'(ID_EX_Bubble), int'(e.bub));
        chk("pipe_hold", int'(pipe_hold), int'(e.hold));
        chk("mem_timeout", int'(mem_timeout), int'(e.to));
        chk("stall_cycles", int'(stall_cycles), e.sc);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] rreg();
    case ($urandom % 5)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  initial begin : stim
    logic [31:0] id, ex;
    logic        rw, mr, mq, my;
    int          burst;

    do_reset();
    @(negedge clk) chk("rst_stall_cycles", int'(stall_cycles), 0);

    // load-use
    step('0, LDUR_OP | 32'd2, 1, 1, 5'd2, 5'd7, 0, 0);
    @(negedge clk) chk("lu_bubble", int'(ID_EX_Bubble), 1);
    idle();
    @(negedge clk) begin
      chk("lu_release", int'(PC_Write), 1);
      chk("lu_count", int'(stall_cycles), 1);
    end

    // CBZ after load
    do_reset();
    step(CBZ_OP | 32'd5, LDUR_OP | 32'd5, 1, 1, 5'd9, 5'd5, 0, 0);
    step(CBZ_OP | 32'd5, '0, 0, 0, 5'd9, 5'd5, 0, 0);
    @(negedge clk) chk("cbzl_second_bubble", int'(ID_EX_Bubble), 1);
    idle();
    @(negedge clk) chk("cbzl_count", int'(stall_cycles), 2);
    step(CBZ_OP | 32'd31, LDUR_OP | 32'd31, 1, 1, 5'd9, 5'd31, 0, 0);
    @(negedge clk) chk("cbzl_x31_nostall", int'(PC_Write), 1);

    // flags
    step(BC_OP, SUBS_OP | 32'd4, 1, 0, 5'd0, 5'd0, 0, 0);
    @(negedge clk) chk("flags_bubble", int'(ID_EX_Bubble), 1);
    step(BC_OP, ADD_OP | 32'd4, 1, 0, 5'd0, 5'd0, 0, 0);
    @(negedge clk) chk("add_nostall", int'(PC_Write), 1);
    step(CBZ_OP | 32'd3, ADDS_OP | 32'd3, 1, 0, 5'd0, 5'd0, 0, 0);

    // memory wait of 3 cycles
    do_reset();
    repeat (3) step('0, '0, 0, 0, 5'd0, 5'd0, 1, 0);
    step('0, '0, 0, 0, 5'd0, 5'd0, 1, 1);
    @(negedge clk) begin
      chk("mw_release", int'(pipe_hold), 0);
      chk("mw_count", int'(stall_cycles), 3);
    end

    // wait arriving in the second CBZ-after-load stall cycle
    do_reset();
    step(CBZ_OP | 32'd5, LDUR_OP | 32'd5, 1, 1, 5'd0, 5'd0, 0, 0);
    repeat (2) step(CBZ_OP | 32'd5, '0, 0, 0, 5'd0, 5'd0, 1, 0);
    step(CBZ_OP | 32'd5, '0, 0, 0, 5'd0, 5'd0, 1, 1);
    @(negedge clk) chk("overlap_resume", int'(ID_EX_Bubble), 1);
    idle();

    // timeout on a 6-cycle wait
    do_reset();
    repeat (3) step('0, '0, 0, 0, 5'd0, 5'd0, 1, 0);
    @(negedge clk) chk("to_before", int'(mem_timeout), 0);
    step('0, '0, 0, 0, 5'd0, 5'd0, 1, 0);
    @(negedge clk) chk("to_rise", int'(mem_timeout), 1);
    repeat (2) step('0, '0, 0, 0, 5'd0, 5'd0, 1, 0);
    step('0, '0, 0, 0, 5'd0, 5'd0, 1, 1);
    idle();
    @(negedge clk) chk("to_sticky", int'(mem_timeout), 1);

    // reset in the middle of a stall
    step(CBZ_OP | 32'd2, LDUR_OP | 32'd2, 1, 1, 5'd0, 5'd0, 0, 0);
    do_reset();
    @(negedge clk) begin
      chk("rst_mid_sc", int'(stall_cycles), 0);
      chk("rst_mid_to", int'(mem_timeout), 0);
    end

    // random traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        burst = 0;
      end
      case ($urandom % 4)
        0: id = BC_OP | ($urandom & 32'h00FF_FFFF);
        1: id = CBZ_OP | (($urandom & 32'h00FF_FFE0)) | 32'(rreg());
        2: id = $urandom;
        default: id = '0;
      endcase
      case ($urandom % 5)
        0: begin ex = LDUR_OP | 32'(rreg()); rw = 1; mr = 1; end
        1: begin ex = SUBS_OP | 32'(rreg()); rw = 1; mr = 0; end
        2: begin ex = ADDS_OP | 32'(rreg()); rw = 1; mr = 0; end
        3: begin ex = ADD_OP | 32'(rreg()); rw = 1; mr = 0; end
        default: begin ex = '0; rw = 0; mr = 0; end
      endcase
      if ($urandom % 10 == 0) rw = ~rw;
      if (burst > 0) begin
        mq = 1; my = 0; burst--;
      end else begin
        mq = ($urandom % 4 == 0);
        my = ($urandom % 2 == 0);
        if ($urandom % 25 == 0) burst = $urandom_range(1, 7);
      end
      step(id, ex, rw, mr, rreg(), rreg(), mq, my);
    end

    idle();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Sequencing controller for the five-stage pipelined ARM datapath. Forwarding alone cannot cover every dependency, so this block decides each cycle whether the front end advances, whether a bubble is injected into ID/EX, or whether the whole pipe freezes on a slow data-memory access. It sits beside the forwarding unit, reads the ID and EX instruction words plus memory handshake signals, and drives the PC, IF/ID, ID/EX and downstream register enables. It also keeps stall and timeout bookkeeping.

## Interface
- MEM_TIMEOUT, 64: wait cycles on one data-memory request before `mem_timeout` asserts.
- CNT_W, 16: width of `stall_cycles`.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- ID_opcode  in  32  instruction word in decode.
- EX_opcode  in  32  instruction word in execute (all-zero = bubble).
- EX_RegWrite  in  1  EX instruction writes `EX_opcode[4:0]`.
- EX_MemRead  in  1  EX instruction is a load (LDUR).
- srcReg1, srcReg2  in  5 each  decode-stage source registers (Rn, Rm/Rt).
- mem_req  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  1 = PC loads next value.
- IF_ID_Write  out  1  1 = IF/ID register loads.
- ID_EX_Bubble  out  1  1 = ID/EX loads zeroed controls (NOP).
- pipe_hold  out  1  1 = ID/EX, EX/MEM and MEM/WB hold their contents.
- stall_cycles  out  CNT_W  saturating count of cycles with PC_Write=0.
- mem_timeout  out  1  sticky error flag.

## Operation
- EX destination `rdEX = EX_opcode[4:0]`. A destination is valid only when it is not 31.
- Decode classes:
  - B.cond: `ID_opcode[31:24]=8'b01010100`.
  - CBZ: `ID_opcode[31:24]=8'b10110100`, with Rt = `ID_opcode[4:0]`.
  - Flag setters (ADDS/SUBS): `EX_opcode[31:21]` = `11'b10101011000` or `11'b11101011000`.
- Hazards and their stall lengths L, evaluated only in state RUN; the longest matching L wins:
  - load-use: EX_MemRead, valid rdEX, and rdEX equals srcReg1 or srcReg2 -> L=1.
  - CBZ register: ID is CBZ, EX_RegWrite, !EX_MemRead, valid rdEX, rdEX = Rt -> L=1.
  - CBZ after load: ID is CBZ, EX_MemRead, valid rdEX, rdEX = Rt -> L=2.
  - flags: ID is B.cond and EX is a flag setter -> L=1.
- Stall cycle outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, pipe_hold=0.
- Memory-wait outputs, whenever `mem_req & !mem_ready`, in any state: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, pipe_hold=1. Memory wait overrides hazard outputs.
- FSM states:
  - RUN: hazard detected (no mem wait) -> emit stall; L=2 -> STALL with cnt=1; L=1 -> stay in RUN. The next cycle re-evaluates and sees the bubble in EX.
  - STALL: emit stall; cnt decrements; go to RUN when cnt reaches 0. Hazards are not re-evaluated in STALL.
  - During memory wait, state and cnt are frozen, and no hazard is latched.
- Wait counter:
  - Increments each memory-wait cycle and clears when the wait ends.
  - Reaching MEM_TIMEOUT sets `mem_timeout`; it stays set until reset. The freeze is unchanged.
- `stall_cycles` increments on every cycle with PC_Write=0 (stall or memory wait) and saturates at all-ones.

## Timing
- Outputs are combinational from the current state and inputs. Hazard response has zero latency: the stall appears in the same cycle the hazard is visible.
- Load-use: one bubble cycle. CBZ after load: two consecutive bubble cycles. Other hazards: one bubble cycle.
- Memory wait lasting N cycles holds the pipe for exactly N cycles. The cycle in which mem_ready=1 is a normal cycle.
- A memory wait arriving mid-STALL freezes cnt. The remaining stall cycles resume after the wait ends.
- Reset (asynchronous, any cycle, including mid-stall or mid-wait) forces: state RUN, cnt 0, wait counter 0, stall_cycles 0, mem_timeout 0.
- With idle inputs during and after reset: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, pipe_hold=0.
- A reset during STALL discards the pending stall.

## Test plan
- Load-use: EX LDUR X2 (EX_MemRead=1, rdEX=2), srcReg1=2 -> one cycle of PC_Write=0 and ID_EX_Bubble=1; next cycle (EX=0) all enables 1; stall_cycles=1.
- CBZ after load: EX LDUR X5, ID CBZ X5 -> two bubble cycles then RUN; stall_cycles=2. Repeat with rdEX=31 -> no stall.
- Flags: EX SUBS (`EX_opcode[31:21]=11101011000`), ID B.cond -> one bubble. EX ADD (non-flag-setting) with ID B.cond -> no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles -> pipe_hold=1 and PC_Write=0 for 3 cycles, ID_EX_Bubble=0; mem_ready on cycle 4 -> release; stall_cycles=3.
- Overlap and timeout: memory wait begins in the second CBZ-after-load stall cycle -> bubble resumes after the wait. With MEM_TIMEOUT=4 and a 6-cycle wait, mem_timeout rises on the 4th wait cycle and stays high.
- Reset mid-STALL: async reset asserted between clock edges -> outputs return to idle values immediately, and stall_cycles and mem_timeout read 0.
